// File: rtl/bram16_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter: FSM state encoding and grant-index width helper.
// Reused by other BRAM controllers that need the same state names or index sizing.
package bram16_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_t;

  // Width of a master index; kept at least 1 so a single-master build still has a legal vector.
  function automatic int grant_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram16_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping past the top index.
// No state and no backpressure; the caller registers the grant and advances ptr.
module rr_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          any
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    any   = |req;
    for (int k = 0; k < N; k++) begin
      logic [GW:0] idx;
      idx = {1'b0, ptr} + (GW+1)'(k);
      if (idx >= (GW+1)'(N)) idx = idx - (GW+1)'(N);
      for (int i = 0; i < N; i++) begin
        if (!found && idx == (GW+1)'(i) && req[i]) begin
          grant = GW'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bram16_arbiter.sv
// Round-robin arbiter sharing one sync-read BRAM port among n_masters; one access per 3 cycles,
// req held until a one-cycle ack that arrives two cycles after the request is sampled.
module bram16_arbiter
  import bram16_arbiter_pkg::*;
#(
  parameter int n_masters  = 2,
  parameter int adr_width  = 11,
  parameter int data_width = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [n_masters-1:0]            m_req,
  input  logic [n_masters-1:0]            m_we,
  input  logic [n_masters*adr_width-1:0]  m_a,
  input  logic [n_masters*data_width-1:0] m_do,
  output logic [n_masters-1:0]            m_ack,
  output logic [data_width-1:0]           m_di,
  output logic [adr_width-1:0]            bram_a,
  output logic [data_width-1:0]           bram_do,
  output logic                            bram_we,
  input  logic [data_width-1:0]           bram_di
);

  localparam int GW = grant_width(n_masters);

  arb_state_t state, state_nxt;
  logic [GW-1:0]         grant_q, ptr_q, pick_g;
  logic                  pick_any;
  logic [adr_width-1:0]  sel_a;
  logic [data_width-1:0] sel_do;
  logic                  sel_we;
  logic [n_masters-1:0]  ack_nxt;

  rr_pick #(.N(n_masters), .GW(GW)) u_pick (
    .req   (m_req),
    .ptr   (ptr_q),
    .grant (pick_g),
    .any   (pick_any)
  );

  always_comb begin
    sel_a  = '0;
    sel_do = '0;
    sel_we = 1'b0;
    for (int i = 0; i < n_masters; i++) begin
      if (pick_g == GW'(i)) begin
        sel_a  = m_a[i*adr_width +: adr_width];
        sel_do = m_do[i*data_width +: data_width];
        sel_we = m_we[i];
      end
    end
  end

  always_comb begin
    ack_nxt = '0;
    for (int i = 0; i < n_masters; i++) ack_nxt[i] = (grant_q == GW'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pick_any) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Master inputs are captured only in IDLE, so later changes never reach the BRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      m_ack   <= '0;
      bram_a  <= '0;
      bram_do <= '0;
      bram_we <= 1'b0;
    end else begin
      state <= state_nxt;
      m_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_g;
            bram_a  <= sel_a;
            bram_do <= sel_do;
            bram_we <= sel_we;
          end else begin
            bram_we <= 1'b0;
          end
        end
        ST_ISSUE: begin
          bram_we <= 1'b0;
          m_ack   <= ack_nxt;
        end
        ST_RESP: begin
          if (grant_q == GW'(n_masters - 1)) ptr_q <= '0;
          else                               ptr_q <= grant_q + 1'b1;
        end
        default: bram_we <= 1'b0;
      endcase
    end
  end

  assign m_di = bram_di;

endmodule

// File: tb/tb_bram16_arbiter.sv
// Directed scenarios followed by a randomized run scored against a transaction-level arbiter model.
module tb_bram16_arbiter;

  localparam int NM = 3;
  localparam int AW = 11;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_we, m_ack;
  logic [NM*AW-1:0]  m_a;
  logic [NM*DW-1:0]  m_do;
  logic [DW-1:0]     m_di, bram_do, bram_di;
  logic [AW-1:0]     bram_a;
  logic              bram_we;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_a  = '0;
  logic [DW-1:0] pl_d  = '0;

  always #5 clk = ~clk;

  bram16_arbiter #(.n_masters(NM), .adr_width(AW), .data_width(DW)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_a(m_a), .m_do(m_do),
    .m_ack(m_ack), .m_di(m_di), .bram_a(bram_a), .bram_do(bram_do),
    .bram_we(bram_we), .bram_di(bram_di)
  );

  // Read-first synchronous BRAM with a backdoor load path.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_a] <= pl_d;
    end else begin
      bram_di <= mem[bram_a];
      if (bram_we) mem[bram_a] <= bram_do;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_a = AW'(a);
    pl_d = d;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic set_m(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_we[i] = we;
    m_a[i*AW +: AW] = a;
    m_do[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    m_req = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Randomized-run model state
  int            next_dec, pend_cyc, pend_g, mptr, n_acks, last_ack, exp_next, diffs;
  bit            pend, pend_we;
  logic [DW-1:0] pend_di;
  bit            req_on [NM];

  initial begin
    rst = 1'b0;
    m_req = '0; m_we = '0; m_a = '0; m_do = '0;
    pl_en = 1'b1;
    for (int a = 0; a < 2048; a++) begin
      pl_a = AW'(a);
      pl_d = DW'(a * 16'h0101) ^ 16'h5A5A;
      ref_mem[a] = pl_d;
      @(negedge clk);
    end
    pl_en = 1'b0;

    // Reset holds everything quiet even with requests pending
    m_req = 3'b011;
    step(); step(); step();
    chk("rst_ack", 32'(m_ack), 0);
    chk("rst_we", 32'(bram_we), 0);
    chk("rst_a", 32'(bram_a), 0);
    chk("rst_do", 32'(bram_do), 0);
    rst = 1'b1;
    step();
    chk("rst_c1_ack", 32'(m_ack), 0);
    step();
    chk("rst_first_ack", 32'(m_ack), 32'b001);
    m_req = '0;
    step();

    // Single write then read-back
    do_reset();
    set_m(0, 1'b1, 11'h010, 16'hBEEF);
    m_req = 3'b001;
    step(); chk("wr_c1_ack", 32'(m_ack), 0);
    step(); chk("wr_ack", 32'(m_ack), 32'b001);
    m_req = '0;
    step();
    set_m(0, 1'b0, 11'h010, 16'h0000);
    m_req = 3'b001;
    step(); chk("rd_c1_ack", 32'(m_ack), 0);
    step(); chk("rd_ack", 32'(m_ack), 32'b001);
    chk("rd_di", 32'(m_di), 32'hBEEF);
    m_req = '0;
    step();
    chk("wr_mem", 32'(mem[11'h010]), 32'hBEEF);
    ref_mem[16] = 16'hBEEF;

    // Contention between m0 and m1
    preload(1, 16'h1111);
    preload(2, 16'h2222);
    do_reset();
    set_m(0, 1'b0, 11'h001, 16'h0);
    set_m(1, 1'b0, 11'h002, 16'h0);
    m_req = 3'b011;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("cont_ack", 32'(m_ack), (c == 2) ? 32'b001 : (c == 5) ? 32'b010 : 32'b000);
      if (c == 2) begin chk("cont_di0", 32'(m_di), 32'h1111); m_req[0] = 1'b0; end
      if (c == 5) begin chk("cont_di1", 32'(m_di), 32'h2222); m_req[1] = 1'b0; end
    end
    step();

    // Fairness with all three masters requesting continuously
    do_reset();
    for (int i = 0; i < NM; i++) set_m(i, 1'b0, AW'(i), 16'h0);
    m_req = 3'b111;
    n_acks = 0; exp_next = 0; last_ack = -10;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (|m_ack) begin
        chk("fair_order", 32'(m_ack), 32'(1 << exp_next));
        chk("fair_gap", 32'(c - last_ack > 1), 1);
        exp_next = (exp_next + 1) % NM;
        n_acks++;
        last_ack = c;
      end
    end
    chk("fair_count", 32'(n_acks), 10);
    m_req = '0;
    step(); step(); step();

    // Inputs changed after grant must not affect the access
    preload(5, 16'h5555);
    preload(6, 16'h6666);
    do_reset();
    set_m(0, 1'b0, 11'h005, 16'h0);
    m_req = 3'b001;
    step();
    chk("stab_bram_a", 32'(bram_a), 32'h005);
    set_m(0, 1'b0, 11'h006, 16'h9999);
    step();
    chk("stab_ack", 32'(m_ack), 32'b001);
    chk("stab_di", 32'(m_di), 32'h5555);
    m_req = '0;
    step();

    // Reset during the ISSUE cycle of a write cancels it
    preload(32, 16'hAAAA);
    do_reset();
    set_m(1, 1'b1, 11'h020, 16'h1234);
    m_req = 3'b010;
    step();
    chk("mid_issue_we", 32'(bram_we), 1);
    rst = 1'b0;
    #1;
    chk("mid_async_we", 32'(bram_we), 0);
    m_req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_no_ack", 32'(m_ack), 0);
    end
    chk("mid_mem", 32'(mem[11'h020]), 32'hAAAA);
    rst = 1'b1;
    set_m(0, 1'b0, 11'h020, 16'h0);
    set_m(1, 1'b0, 11'h001, 16'h0);
    m_req = 3'b011;
    step();
    step();
    chk("post_rst_ptr", 32'(m_ack), 32'b001);
    chk("post_rst_di", 32'(m_di), 32'hAAAA);
    m_req = '0;
    step();

    // Randomized traffic against a transaction-level model
    do_reset();
    pend = 1'b0; next_dec = cyc; mptr = 0;
    for (int i = 0; i < NM; i++) req_on[i] = 1'b0;
    for (int n = 0; n < 900; n++) begin
      if (pend && pend_cyc == cyc) begin
        chk("rnd_ack", 32'(m_ack), 32'(1 << pend_g));
        if (!pend_we) chk("rnd_di", 32'(m_di), 32'(pend_di));
        req_on[pend_g] = 1'b0;
        pend = 1'b0;
      end else begin
        chk("rnd_idle_ack", 32'(m_ack), 0);
      end
      for (int i = 0; i < NM; i++) begin
        if (!req_on[i] && n < 880 && $urandom_range(0, 2) == 0) req_on[i] = 1'b1;
        set_m(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
        m_req[i] = req_on[i];
      end
      if (cyc == next_dec) begin
        if (|m_req) begin
          int g, a;
          g = -1;
          for (int k = 0; k < NM; k++)
            if (g < 0 && m_req[(mptr + k) % NM]) g = (mptr + k) % NM;
          a = int'(m_a[g*AW +: AW]);
          pend = 1'b1; pend_cyc = cyc + 2; pend_g = g;
          pend_we = m_we[g];
          pend_di = ref_mem[a];
          if (pend_we) ref_mem[a] = m_do[g*DW +: DW];
          mptr = (g + 1) % NM;
          next_dec = cyc + 3;
        end else begin
          next_dec = cyc + 1;
        end
      end
      step();
    end
    diffs = 0;
    for (int a = 0; a < 64; a++) if (mem[a] !== ref_mem[a]) diffs++;
    chk("rnd_mem_diffs", 32'(diffs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
